// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving two requesters single-transaction access to one data memory,
// with a per-transaction acknowledge timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        b_req,
  input  logic        a_we,
  input  logic        b_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] b_addr,
  input  logic [31:0] a_wdata,
  input  logic [31:0] b_wdata,
  output logic        a_done,
  output logic        b_done,
  output logic        a_err,
  output logic        b_err,
  output logic [31:0] a_rdata,
  output logic [31:0] b_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_read_acc,
  input  logic        mem_write_acc
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic last_b, sel_b, we_l, grant, gnt_b, ack, tmo, fin;
  logic [31:0] addr_l, wdata_l;
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    grant = a_req | b_req;
    gnt_b = b_req & (~a_req | ~last_b);
    ack = we_l ? mem_write_acc : mem_read_acc;
    tmo = cnt == 8'(TIMEOUT - 1);
    fin = state == ACCESS && (ack || tmo);
    state_nx = state == IDLE ? (grant ? ACCESS : IDLE) :
               state == ACCESS ? (fin ? RESP : ACCESS) : IDLE;
  end
  // Strobes come straight from the latched request so they are glitch-free and zero outside ACCESS.
  assign mem_read  = state == ACCESS && !we_l;
  assign mem_write = state == ACCESS && we_l;
  assign mem_addr  = state == ACCESS ? addr_l : 32'd0;
  assign mem_wdata = state == ACCESS ? wdata_l : 32'd0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      last_b <= 1'b1;
      sel_b <= 1'b0;
      we_l <= 1'b0;
      addr_l <= 32'd0;
      wdata_l <= 32'd0;
      cnt <= 8'd0;
      a_done <= 1'b0;
      b_done <= 1'b0;
      a_err <= 1'b0;
      b_err <= 1'b0;
      a_rdata <= 32'd0;
      b_rdata <= 32'd0;
    end else begin
      a_done <= 1'b0;
      b_done <= 1'b0;
      a_err <= 1'b0;
      b_err <= 1'b0;
      if (state == IDLE && grant) begin
        sel_b <= gnt_b;
        last_b <= gnt_b;
        we_l <= gnt_b ? b_we : a_we;
        addr_l <= gnt_b ? b_addr : a_addr;
        wdata_l <= gnt_b ? b_wdata : a_wdata;
        cnt <= 8'd0;
      end
      // An acknowledge on the timeout cycle still counts as success.
      if (fin) begin
        a_done <= !sel_b;
        b_done <= sel_b;
        a_err <= !sel_b && !ack;
        b_err <= sel_b && !ack;
        if (ack && !we_l && !sel_b) a_rdata <= mem_rdata;
        if (ack && !we_l && sel_b) b_rdata <= mem_rdata;
      end else if (state == ACCESS) cnt <= cnt + 8'd1;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic a_req = 0, b_req = 0, a_we = 0, b_we = 0;
  logic [31:0] a_addr = 0, b_addr = 0, a_wdata = 0, b_wdata = 0, mem_rdata = 0;
  logic mem_read_acc = 0, mem_write_acc = 0;
  logic a_done, b_done, a_err, b_err, mem_read, mem_write;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata;
  int n_checks = 0, n_fail = 0;
  mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_done(a_done), .b_done(b_done), .a_err(a_err), .b_err(b_err),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read_acc(mem_read_acc), .mem_write_acc(mem_write_acc)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_quiet(input string tag);
    check({tag, "_adone"}, a_done, 0);
    check({tag, "_bdone"}, b_done, 0);
    check({tag, "_mrd"}, mem_read, 0);
    check({tag, "_mwr"}, mem_write, 0);
  endtask
  initial begin
    logic [31:0] saved;
    logic [31:0] exp_addr [3];
    logic exp_b [3];
    exp_addr[0] = 32'h100; exp_addr[1] = 32'h200; exp_addr[2] = 32'h100;
    exp_b[0] = 0; exp_b[1] = 1; exp_b[2] = 0;
    tick(); tick();
    idle_quiet("rst");
    check("rst_arda", a_rdata, 0);
    check("rst_brda", b_rdata, 0);
    check("rst_maddr", mem_addr, 0);
    reset = 0;
    // single A read with immediate ack
    a_req = 1; a_we = 0; a_addr = 32'h10; mem_read_acc = 1; mem_rdata = 32'h12345678;
    tick();
    check("rd_mrd", mem_read, 1);
    check("rd_mwr", mem_write, 0);
    check("rd_maddr", mem_addr, 32'h10);
    check("rd_adone0", a_done, 0);
    a_req = 0;
    tick();
    check("rd_adone", a_done, 1);
    check("rd_aerr", a_err, 0);
    check("rd_bdone", b_done, 0);
    check("rd_arda", a_rdata, 32'h12345678);
    check("rd_mrd_off", mem_read, 0);
    mem_read_acc = 0;
    tick();
    idle_quiet("rd_end");
    // B write, ack one cycle after mem_write is sampled
    b_req = 1; b_we = 1; b_addr = 32'h40000000; b_wdata = 32'hA5;
    tick();
    check("wr_mwr1", mem_write, 1);
    check("wr_mrd1", mem_read, 0);
    check("wr_maddr", mem_addr, 32'h40000000);
    check("wr_mwdata", mem_wdata, 32'hA5);
    b_req = 0;
    tick();
    check("wr_mwr2", mem_write, 1);
    check("wr_bdone0", b_done, 0);
    mem_write_acc = 1;
    tick();
    check("wr_bdone", b_done, 1);
    check("wr_berr", b_err, 0);
    check("wr_adone", a_done, 0);
    check("wr_mwr_off", mem_write, 0);
    check("wr_brda", b_rdata, 0);
    mem_write_acc = 0;
    tick();
    idle_quiet("wr_end");
    // both requesting reads: order A, B, A
    a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 32'h100; b_addr = 32'h200;
    mem_read_acc = 1;
    for (int i = 0; i < 3; i++) begin
      mem_rdata = 32'hA0000000 + i;
      tick();
      check($sformatf("rr%0d_maddr", i), mem_addr, exp_addr[i]);
      check($sformatf("rr%0d_mrd", i), mem_read, 1);
      check($sformatf("rr%0d_mwr", i), mem_write, 0);
      tick();
      check($sformatf("rr%0d_adone", i), a_done, !exp_b[i]);
      check($sformatf("rr%0d_bdone", i), b_done, exp_b[i]);
      check($sformatf("rr%0d_rdata", i), exp_b[i] ? b_rdata : a_rdata, 32'hA0000000 + i);
      if (i == 2) begin a_req = 0; b_req = 0; end
      tick();
      idle_quiet($sformatf("rr%0d_gap", i));
    end
    mem_read_acc = 0;
    // A read that never gets acked times out after 8 ACCESS cycles
    saved = a_rdata;
    a_req = 1; a_addr = 32'h80000000;
    tick();
    a_req = 0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("to%0d_mrd", i), mem_read, 1);
      check($sformatf("to%0d_adone", i), a_done, 0);
      tick();
    end
    check("to_adone", a_done, 1);
    check("to_aerr", a_err, 1);
    check("to_arda", a_rdata, saved);
    tick();
    idle_quiet("to_end");
    check("to_aerr_off", a_err, 0);
    // ack on the timeout cycle wins
    a_req = 1; a_addr = 32'h20;
    tick();
    a_req = 0;
    for (int i = 0; i < 7; i++) tick();
    check("tw_mrd", mem_read, 1);
    mem_read_acc = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    check("tw_adone", a_done, 1);
    check("tw_aerr", a_err, 0);
    check("tw_arda", a_rdata, 32'hCAFEF00D);
    mem_read_acc = 0;
    tick();
    // spurious acks in IDLE are ignored
    mem_read_acc = 1; mem_write_acc = 1; mem_rdata = 32'hDEADBEEF;
    tick(); tick();
    idle_quiet("sp");
    check("sp_arda", a_rdata, 32'hCAFEF00D);
    check("sp_brda", b_rdata, 32'hA0000001);
    mem_read_acc = 0; mem_write_acc = 0;
    // reset in the middle of a B write aborts it silently
    b_req = 1; b_we = 1; b_addr = 32'h44; b_wdata = 32'h77;
    tick();
    b_req = 0;
    check("ra_mwr", mem_write, 1);
    reset = 1;
    #1;
    check("ra_mwr_off", mem_write, 0);
    check("ra_maddr", mem_addr, 0);
    check("ra_arda", a_rdata, 0);
    check("ra_brda", b_rdata, 0);
    tick();
    idle_quiet("ra_held");
    reset = 0;
    tick();
    idle_quiet("ra_rel");
    a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 32'h300; b_addr = 32'h400;
    mem_read_acc = 1; mem_rdata = 32'h55;
    tick();
    check("ra_first", mem_addr, 32'h300);
    a_req = 0; b_req = 0;
    tick();
    check("ra_adone", a_done, 1);
    check("ra_bdone", b_done, 0);
    mem_read_acc = 0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8: max ACCESS cycles without acknowledge before error completion; legal range 2..255.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 a_req, b_req  input  1 each  access request from requester A (CPU) and requester B (DMA/loader).
REQ-005 a_we, b_we  input  1 each  1 = write, 0 = read.
REQ-006 a_addr, b_addr  input  32 each  byte address.
REQ-007 a_wdata, b_wdata  input  32 each  write data.
REQ-008 a_done, b_done  output  1 each  one-cycle completion pulse.
REQ-009 a_err, b_err  output  1 each  valid with done; 1 = timeout.
REQ-010 a_rdata, b_rdata  output  32 each  read data, held until that port's next done.
REQ-011 mem_read, mem_write  output  1 each  strobes to data memory.
REQ-012 mem_addr, mem_wdata  output  32 each  address and write data to data memory.
REQ-013 mem_rdata  input  32  read data from memory, valid when mem_read_acc=1.
REQ-014 mem_read_acc  input  1  combinational read acknowledge, same cycle as mem_read.
REQ-015 mem_write_acc  input  1  registered write acknowledge, arrives cycle after mem_write sampled.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; all outputs registered except mem_* driven from latched registers.
REQ-017 IDLE: if any req, select requester, latch its we/addr/wdata, clear counter, go ACCESS next cycle; no req -> stay IDLE.
REQ-018 Arbitration round-robin: pointer last_grant; both req -> grant the one not last granted; single req -> grant it regardless of pointer.
REQ-019 last_grant updates only at grant time.
REQ-020 ACCESS: mem_read = ~we_latched, mem_write = we_latched, mem_addr/mem_wdata = latched values; all mem_* 0 outside ACCESS.
REQ-021 ACCESS read: cycle where mem_read_acc=1 -> capture mem_rdata into granted port's rdata, go RESP with err=0.
REQ-022 ACCESS write: cycle where mem_write_acc=1 -> go RESP with err=0; rdata of that port unchanged.
REQ-023 Counter increments each ACCESS cycle without acknowledge; counter reaching TIMEOUT-1 without ack -> go RESP with err=1, rdata unchanged.
REQ-024 Acknowledge in same cycle as timeout -> success wins (err=0).
REQ-025 RESP: pulse granted port's done for exactly one cycle with err; other port's done/err = 0; next state IDLE.
REQ-026 Min transaction: grant cycle + 1 ACCESS + RESP = 3 cycles request-to-done for read; write ack adds 1 ACCESS cycle.
REQ-027 req sampled only in IDLE; deassertion during ACCESS/RESP does not abort; transaction completes and done still pulses.
REQ-028 Requester holding req after done is re-arbitrated in the following IDLE cycle (one idle bubble between transactions).
REQ-029 mem_read and mem_write never asserted together; at most one transaction outstanding.
REQ-030 Acknowledges arriving outside ACCESS are ignored.

Reset
REQ-031 reset asserted (any state, incl. mid-ACCESS): state IDLE, last_grant = B (so A wins first tie), counter 0, all done/err/mem_* 0, a_rdata = b_rdata = 0; no done pulse for aborted transaction.
REQ-032 After reset release, first arbitration occurs at the first rising edge with req asserted.

Verification
REQ-033 a_req read addr 0x00000010, mem_read_acc=1 with rdata 0x12345678 -> a_done pulse, a_err=0, a_rdata=0x12345678, 3 cycles after request.
REQ-034 a_req and b_req asserted together, both held through two transactions -> grant order A, B, A; each done exactly one cycle; no overlap of mem strobes.
REQ-035 b_req write addr 0x40000000 data 0xA5, mem_write_acc returned 1 cycle later -> b_done, b_err=0, mem_write high exactly 2 cycles.
REQ-036 a_req read addr 0x80000000, no ack ever, TIMEOUT=8 -> a_done with a_err=1 after 8 ACCESS cycles, a_rdata unchanged, FSM back to IDLE.
REQ-037 reset pulsed during ACCESS of a B write -> all outputs 0 next edge, no b_done; after release a_req and b_req together -> A granted first.
REQ-038 Spurious mem_read_acc/mem_write_acc in IDLE -> no done, no rdata change.
